// File: rtl/slv_ram_pkg.sv
// Shared state type, latency bounds and counter widths for slv_ram_banked.
package slv_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int CNT_W      = 16;
  localparam int PERR_CNT_W = 8;

endpackage

// File: rtl/slv_ram_array.sv
// Single-port synchronous RAM with byte enables; read data registered (1 cycle), no backpressure.
// With SLV_RAM_PARITY_EN each lane carries an even-parity bit checked on the read register.
module slv_ram_array #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 512,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              perr_o
);

`ifdef SLV_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + SEL_W;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0] mem_q [DEPTH];
  logic [MEM_W-1:0] rd_q;

  // Read register only updates on reads, so it keeps its value across writes.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < SEL_W; i++) begin
          if (sel_i[i]) begin
            mem_q[adr_i][8*i +: 8] <= dat_i[8*i +: 8];
`ifdef SLV_RAM_PARITY_EN
            mem_q[adr_i][DATA_W+i] <= ^dat_i[8*i +: 8];
`endif
          end
        end
      end else begin
        rd_q <= mem_q[adr_i];
      end
    end
  end

  assign dat_o = rd_q[DATA_W-1:0];

`ifdef SLV_RAM_PARITY_EN
  always_comb begin
    perr_o = 1'b0;
    for (int i = 0; i < SEL_W; i++) begin
      if ((^rd_q[8*i +: 8]) != rd_q[DATA_W+i]) perr_o = 1'b1;
    end
  end
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/slv_ram_banked.sv
// Self-clearing slave RAM: RD_LAT-cycle pipelined reads, slv_rdy_o low during the DEPTH-cycle clear.
// Optional lane parity via SLV_RAM_PARITY_EN; counters saturate and survive clr_i.
module slv_ram_banked
  import slv_ram_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 512,
  parameter  int RD_LAT = 1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic                  pcie_clk,
  input  logic                  sys_rst,
  input  logic                  clr_i,
  input  logic                  slv_ce_i,
  input  logic                  slv_we_i,
  input  logic [ADDR_W-1:0]     slv_adr_i,
  input  logic [DATA_W-1:0]     slv_dat_i,
  input  logic [SEL_W-1:0]      slv_sel_i,
  output logic [DATA_W-1:0]     slv_dat_o,
  output logic                  slv_rvalid_o,
  output logic                  slv_rdy_o,
  output logic [CNT_W-1:0]      rd_cnt_o,
  output logic [CNT_W-1:0]      wr_cnt_o,
  output logic                  perr_o,
  output logic [PERR_CNT_W-1:0] perr_cnt_o
);

  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       init_adr_q, init_adr_d;
  logic                    in_init, acc, rd_acc, wr_acc;
  logic                    ram_en, ram_we, ram_perr;
  logic [ADDR_W-1:0]       ram_adr;
  logic [DATA_W-1:0]       ram_wdat, ram_rdat;
  logic [SEL_W-1:0]        ram_sel;
  logic [LAT-1:0]          vld_q, vld_d;
  logic [DATA_W:0]         stg [LAT];
  logic [DATA_W-1:0]       hold_q;
  logic [CNT_W-1:0]        rd_cnt_q, wr_cnt_q;
  logic [PERR_CNT_W-1:0]   perr_cnt_q;

  assign in_init   = (state_q == ST_INIT);
  assign slv_rdy_o = (state_q == ST_RUN);
  assign acc       = slv_ce_i & slv_rdy_o & ~sys_rst;
  assign rd_acc    = acc & ~slv_we_i;
  assign wr_acc    = acc & slv_we_i;

  always_comb begin
    state_d    = state_q;
    init_adr_d = init_adr_q;
    case (state_q)
      ST_INIT: begin
        if (clr_i) begin
          init_adr_d = '0;
        end else if (init_adr_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = ST_RUN;
          init_adr_d = '0;
        end else begin
          init_adr_d = init_adr_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clr_i) begin
          state_d    = ST_INIT;
          init_adr_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      state_q    <= ST_INIT;
      init_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_adr_q <= init_adr_d;
    end
  end

  // INIT owns the RAM port: zero data, all lanes, sweeping address.
  assign ram_en   = in_init | acc;
  assign ram_we   = in_init | slv_we_i;
  assign ram_adr  = in_init ? init_adr_q : slv_adr_i;
  assign ram_wdat = in_init ? '0 : slv_dat_i;
  assign ram_sel  = in_init ? '1 : slv_sel_i;

  slv_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i  (pcie_clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .adr_i  (ram_adr),
    .dat_i  (ram_wdat),
    .sel_i  (ram_sel),
    .dat_o  (ram_rdat),
    .perr_o (ram_perr)
  );

  // Stage 0 is the RAM read register; later stages add the extra latency.
  assign stg[0] = {ram_perr, ram_rdat};
  for (genvar k = 1; k < LAT; k++) begin : g_stg
    logic [DATA_W:0] stg_q;
    always_ff @(posedge pcie_clk) stg_q <= stg[k-1];
    assign stg[k] = stg_q;
  end

  // clr_i drops every pending read; the one emerging this cycle still goes out.
  always_comb begin
    vld_d = '0;
    if (!clr_i) begin
      vld_d[0] = rd_acc;
      for (int k = 1; k < LAT; k++) vld_d[k] = vld_q[k-1];
    end
  end

  assign slv_rvalid_o = vld_q[LAT-1];
  assign slv_dat_o    = slv_rvalid_o ? stg[LAT-1][DATA_W-1:0] : hold_q;
  assign perr_o       = slv_rvalid_o & stg[LAT-1][DATA_W];
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;
  assign perr_cnt_o   = perr_cnt_q;

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      vld_q      <= '0;
      hold_q     <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      perr_cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (slv_rvalid_o) hold_q <= stg[LAT-1][DATA_W-1:0];
      if (rd_acc && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (wr_acc && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (perr_o && perr_cnt_q != '1) perr_cnt_q <= perr_cnt_q + PERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_slv_ram_banked.sv
// Directed bench: instance A is 16-bit/RD_LAT=1, instance B is 32-bit/RD_LAT=2, both DEPTH=512.
module tb_slv_ram_banked;

  localparam int DEPTH = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr_a, clr_b;

  logic        a_ce, a_we, a_rv, a_rdy, a_perr;
  logic [8:0]  a_adr;
  logic [15:0] a_wd, a_rd, a_rcnt, a_wcnt;
  logic [1:0]  a_sel;
  logic [7:0]  a_pcnt;

  logic        b_ce, b_we, b_rv, b_rdy, b_perr;
  logic [8:0]  b_adr;
  logic [31:0] b_wd, b_rd;
  logic [15:0] b_rcnt, b_wcnt;
  logic [3:0]  b_sel;
  logic [7:0]  b_pcnt;

  int n_chk, n_pass, rd_exp, wr_exp;

  slv_ram_banked #(.DATA_W(16), .DEPTH(DEPTH), .RD_LAT(1)) u_dut_a (
    .pcie_clk(clk), .sys_rst(rst), .clr_i(clr_a),
    .slv_ce_i(a_ce), .slv_we_i(a_we), .slv_adr_i(a_adr), .slv_dat_i(a_wd), .slv_sel_i(a_sel),
    .slv_dat_o(a_rd), .slv_rvalid_o(a_rv), .slv_rdy_o(a_rdy),
    .rd_cnt_o(a_rcnt), .wr_cnt_o(a_wcnt), .perr_o(a_perr), .perr_cnt_o(a_pcnt)
  );

  slv_ram_banked #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT(2)) u_dut_b (
    .pcie_clk(clk), .sys_rst(rst), .clr_i(clr_b),
    .slv_ce_i(b_ce), .slv_we_i(b_we), .slv_adr_i(b_adr), .slv_dat_i(b_wd), .slv_sel_i(b_sel),
    .slv_dat_o(b_rd), .slv_rvalid_o(b_rv), .slv_rdy_o(b_rdy),
    .rd_cnt_o(b_rcnt), .wr_cnt_o(b_wcnt), .perr_o(b_perr), .perr_cnt_o(b_pcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Counts observed not-ready cycles, starting in the current cycle.
  task automatic wait_rdy(input string tag, input bit sel_b);
    int n = 0;
    while (!(sel_b ? b_rdy : a_rdy) && n < 2000) begin
      n++;
      tick();
    end
    chk(tag, 64'(n), 64'(DEPTH));
  endtask

  task automatic a_op(input logic we, input logic [8:0] adr, input logic [15:0] wd, input logic [1:0] sel);
    a_ce = 1'b1; a_we = we; a_adr = adr; a_wd = wd; a_sel = sel;
    tick();
    a_ce = 1'b0; a_we = 1'b0;
  endtask

  task automatic b_op(input logic we, input logic [8:0] adr, input logic [31:0] wd, input logic [3:0] sel);
    b_ce = 1'b1; b_we = we; b_adr = adr; b_wd = wd; b_sel = sel;
    tick();
    b_ce = 1'b0; b_we = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; rd_exp = 0; wr_exp = 0;
    rst = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    a_ce = 1'b0; a_we = 1'b0; a_adr = '0; a_wd = '0; a_sel = '0;
    b_ce = 1'b0; b_we = 1'b0; b_adr = '0; b_wd = '0; b_sel = '0;
    repeat (3) tick();

    chk("rst_rdy", a_rdy, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_dat", a_rd, 0);
    chk("rst_rcnt", a_rcnt, 0);
    chk("rst_wcnt", a_wcnt, 0);
    chk("rst_perr", a_perr, 0);
    chk("rst_pcnt", a_pcnt, 0);
    chk("rst_rdy_b", b_rdy, 0);

    // Writes issued throughout INIT must be dropped.
    rst = 1'b0;
    a_ce = 1'b1; a_we = 1'b1; a_adr = 9'd3; a_wd = 16'h7777; a_sel = 2'b11;
    wait_rdy("init_len", 1'b0);
    a_ce = 1'b0;
    chk("init_rdy_b", b_rdy, 1);
    chk("drop_wcnt", a_wcnt, 0);

    a_op(1'b0, 9'h1A5, 16'h0, 2'b00); rd_exp++;
    chk("rd_1a5_rv", a_rv, 1);
    chk("rd_1a5", a_rd, 16'h0000);

    // Write then read the same address next cycle.
    a_ce = 1'b1; a_we = 1'b1; a_adr = 9'd5; a_wd = 16'h1234; a_sel = 2'b11;
    tick(); wr_exp++;
    chk("wtr_rv_early", a_rv, 0);
    a_we = 1'b0;
    tick(); rd_exp++;
    a_ce = 1'b0;
    chk("wtr_rv", a_rv, 1);
    chk("wtr_dat", a_rd, 16'h1234);
    tick();
    chk("hold_rv", a_rv, 0);
    chk("hold_dat", a_rd, 16'h1234);

    a_op(1'b1, 9'd6, 16'hABCD, 2'b11);
    a_op(1'b1, 9'd6, 16'h5500, 2'b10);
    a_op(1'b1, 9'd6, 16'hFFFF, 2'b00);
    a_op(1'b0, 9'd6, 16'h0, 2'b00);
    wr_exp += 3; rd_exp++;
    chk("lane_merge", a_rd, 16'h55CD);

    a_op(1'b1, 9'd511, 16'hBEEF, 2'b11);
    a_op(1'b1, 9'd0, 16'h0F0F, 2'b11);
    a_op(1'b1, 9'h1A5, 16'h7E7E, 2'b11);
    wr_exp += 3;
    a_op(1'b0, 9'd511, 16'h0, 2'b00); chk("last_word", a_rd, 16'hBEEF);
    a_op(1'b0, 9'd0, 16'h0, 2'b00);   chk("first_word", a_rd, 16'h0F0F);
    a_op(1'b0, 9'd3, 16'h0, 2'b00);   chk("dropped_wr", a_rd, 16'h0000);
    rd_exp += 3;
    chk("wcnt", a_wcnt, 64'(wr_exp));
    chk("rcnt", a_rcnt, 64'(rd_exp));

`ifdef SLV_RAM_PARITY_EN
    a_op(1'b1, 9'd7, 16'h00FF, 2'b11);
    a_op(1'b1, 9'd8, 16'h0101, 2'b11);
    wr_exp += 2;
    u_dut_a.u_array.mem_q[7][16] = ~u_dut_a.u_array.mem_q[7][16];
    a_op(1'b0, 9'd7, 16'h0, 2'b00);
    chk("perr_rv", a_rv, 1);
    chk("perr_hit", a_perr, 1);
    chk("perr_cnt", a_pcnt, 1);
    a_op(1'b0, 9'd8, 16'h0, 2'b00);
    chk("perr_clean", a_perr, 0);
    rd_exp += 2;
`endif

    // Four back-to-back reads, clr_i right after the last accept.
    a_ce = 1'b1; a_we = 1'b0; a_adr = 9'd5;
    tick(); chk("b2b0", a_rv ? a_rd : 16'hxxxx, 16'h1234);
    a_adr = 9'd6;   tick(); chk("b2b1", a_rv ? a_rd : 16'hxxxx, 16'h55CD);
    a_adr = 9'd511; tick(); chk("b2b2", a_rv ? a_rd : 16'hxxxx, 16'hBEEF);
    a_adr = 9'd0;   tick(); chk("b2b3", a_rv ? a_rd : 16'hxxxx, 16'h0F0F);
    a_ce = 1'b0; clr_a = 1'b1;
    tick(); clr_a = 1'b0; rd_exp += 4;
    chk("clr_rv", a_rv, 0);
    chk("clr_hold", a_rd, 16'h0F0F);
    chk("clr_rcnt", a_rcnt, 64'(rd_exp));
    wait_rdy("clr_init", 1'b0);
    a_op(1'b0, 9'h1A5, 16'h0, 2'b00); chk("cleared_1a5", a_rd, 16'h0000);
    a_op(1'b0, 9'd5, 16'h0, 2'b00);   chk("cleared_5", a_rd, 16'h0000);
    rd_exp += 2;

    // clr_i mid-INIT restarts the full sweep.
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    repeat (100) tick();
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    wait_rdy("clr_in_init", 1'b0);

    b_op(1'b1, 9'h10, 32'hDEADBEEF, 4'hF);
    b_op(1'b1, 9'h10, 32'h00110000, 4'h4);
    b_ce = 1'b1; b_we = 1'b0; b_adr = 9'h10;
    tick(); b_ce = 1'b0;
    chk("b_lat_early", b_rv, 0);
    tick();
    chk("b_lat_rv", b_rv, 1);
    chk("b_lane_merge", b_rd, 32'hDE11BEEF);
    tick();
    chk("b_hold", b_rd, 32'hDE11BEEF);

    b_op(1'b1, 9'h11, 32'hCAFEF00D, 4'hF);
    b_op(1'b1, 9'h12, 32'h01234567, 4'h3);
    b_ce = 1'b1; b_we = 1'b0; b_adr = 9'h10;
    tick(); b_adr = 9'h11;
    tick(); chk("b_b2b0", b_rv ? b_rd : 32'hxxxxxxxx, 32'hDE11BEEF); b_adr = 9'h12;
    tick(); chk("b_b2b1", b_rv ? b_rd : 32'hxxxxxxxx, 32'hCAFEF00D); b_adr = 9'h13;
    tick(); chk("b_b2b2", b_rv ? b_rd : 32'hxxxxxxxx, 32'h00004567);
    b_ce = 1'b0; clr_b = 1'b1;
    tick(); clr_b = 1'b0;
    chk("b_flush_rv", b_rv, 0);
    chk("b_flush_rcnt", b_rcnt, 5);
    wait_rdy("b_clr_init", 1'b1);

    // Saturate the write counter.
    a_ce = 1'b1; a_we = 1'b1; a_adr = 9'd9; a_wd = 16'h0001; a_sel = 2'b11;
    repeat (65540) tick();
    a_ce = 1'b0; a_we = 1'b0;
    chk("wcnt_sat", a_wcnt, 16'hFFFF);
    chk("rcnt_keep", a_rcnt, 64'(rd_exp));

    // Reset during A's INIT and during a pending B read.
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    repeat (10) tick();
    b_ce = 1'b1; b_we = 1'b0; b_adr = 9'h10;
    tick(); b_ce = 1'b0; rst = 1'b1;
    tick();
    chk("rst_abort_rv", b_rv, 0);
    chk("rst_wcnt0", a_wcnt, 0);
    chk("rst_rcnt0", a_rcnt, 0);
    chk("rst_b_rcnt0", b_rcnt, 0);
    rst = 1'b0;
    wait_rdy("rst_reinit", 1'b0);
    chk("rst_reinit_b", b_rdy, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/slv_ram_banked.md
SLV_RAM_BANKED -- requirements
Module: slv_ram_banked

Interface
REQ-001 Parameter DATA_W, default 16, slave data width; legal values 16, 32 and 64.
REQ-002 Parameter DEPTH, default 512, number of words; power of two, minimum 16.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 to 3.
REQ-004 Derived constant ADDR_W SHALL equal clog2(DEPTH), and SEL_W SHALL equal DATA_W/8.
REQ-005 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
- pcie_clk  in  1  sole clock
- sys_rst  in  1  synchronous active-high reset
- clr_i  in  1  one-cycle pulse; restarts array clear
- slv_ce_i  in  1  access strobe
- slv_we_i  in  1  1 = write, 0 = read
- slv_adr_i  in  ADDR_W  word address
- slv_dat_i  in  DATA_W  write data
- slv_sel_i  in  SEL_W  byte-lane enables
- slv_dat_o  out  DATA_W  read data
- slv_rvalid_o  out  1  read data valid
- slv_rdy_o  out  1  ready to accept accesses
- rd_cnt_o  out  16  accepted-read count, saturating
- wr_cnt_o  out  16  accepted-write count, saturating
- perr_o  out  1  parity error flag, qualified by slv_rvalid_o
- perr_cnt_o  out  8  parity error count, saturating

Function
REQ-006 The FSM SHALL have two states. INIT writes zero, with all lanes enabled, to address 0, 1, ... DEPTH-1, one address per cycle. RUN services the slave bus.
REQ-007 INIT SHALL last exactly DEPTH cycles and then move to RUN. slv_rdy_o SHALL be 0 in INIT and 1 in RUN.
REQ-008 An access is accepted in a cycle where slv_ce_i=1 and slv_rdy_o=1. Accesses while slv_rdy_o=0 SHALL be dropped without effect and not counted.
REQ-009 An accepted write SHALL update only the byte lanes whose slv_sel_i bit is 1. sel=0 is accepted and counted but changes nothing.
REQ-010 An accepted read at cycle t SHALL present data on slv_dat_o with slv_rvalid_o=1 in cycle t+RD_LAT.
REQ-011 Back-to-back reads SHALL give one result per cycle, fully pipelined.
REQ-012 A read in the cycle after a write to the same address SHALL return the newly written data (write-then-read, no stale data).
REQ-013 slv_dat_o SHALL hold its last value while slv_rvalid_o=0.
REQ-014 clr_i in RUN SHALL flush the read pipeline and enter INIT at address 0 on the next cycle. Flushed reads never assert slv_rvalid_o.
REQ-015 clr_i during INIT SHALL restart INIT at address 0.
REQ-016 Each of rd_cnt_o and wr_cnt_o SHALL increment by 1 per accepted access and saturate at 16'hFFFF. clr_i SHALL NOT reset the counters.
REQ-017 slv_adr_i is a word address with no wrap or aliasing. Address DEPTH-1 is the last word.

Reset
REQ-018 While sys_rst=1 the outputs SHALL be: slv_dat_o 0, slv_rvalid_o 0, slv_rdy_o 0, all counters 0, perr_o 0. The read pipeline SHALL be empty.
REQ-019 After sys_rst deasserts, the block SHALL enter INIT at address 0.
REQ-020 sys_rst asserted mid-INIT or mid-read SHALL abort the operation. No pending slv_rvalid_o SHALL emerge after reset.

Configuration
REQ-021 With SLV_RAM_PARITY_EN defined:
- the array stores one even-parity bit per byte lane;
- parity is written with the lane data, and INIT writes consistent parity;
- on each valid read, perr_o=1 if any lane mismatches;
- perr_cnt_o increments on such a read and saturates at 8'hFF.
REQ-022 Without SLV_RAM_PARITY_EN, the array SHALL be DATA_W wide and perr_o and perr_cnt_o SHALL be constant 0.

Structure
REQ-023 Package slv_ram_pkg SHALL hold:
- the FSM state enumeration (INIT, RUN);
- RD_LAT_MIN=1 and RD_LAT_MAX=3;
- counter widths 16 and 8.
REQ-024 Sub-module slv_ram_array SHALL be the inferred single-port synchronous RAM with byte enables (and parity bits when enabled). The top holds the FSM, the latency pipeline and the counters.

Verification
REQ-025 Reset, then idle: slv_rdy_o=0 for exactly DEPTH cycles (512), then 1. A read of address 0x1A5 returns 0.
REQ-026 DATA_W=32, RD_LAT=2: write 0xDEADBEEF to 0x010 with sel=4'hF, then write 0x00110000 with sel=4'h4. A read of 0x010 returns 0xDE11BEEF, with slv_rvalid_o two cycles after accept.
REQ-027 Write 0x1234 to address 5 at cycle t, read address 5 at t+1 with RD_LAT=1: slv_dat_o=0x1234 at t+2.
REQ-028 Issue 4 back-to-back reads, then clr_i in the cycle after the last accept: slv_rvalid_o only for reads already due; slv_rdy_o=0 for 512 cycles; rd_cnt_o=4.
REQ-029 With SLV_RAM_PARITY_EN, force one stored parity bit of address 7 in the bench, then read address 7: perr_o=1 with slv_rvalid_o and perr_cnt_o=1. A read of address 8 gives perr_o=0.
REQ-030 Issue 65540 writes: wr_cnt_o=16'hFFFF. Assert sys_rst during INIT: counters 0 and INIT restarts at address 0.
